// File: rtl/fetch_sequencer_pkg.sv
// Shared fetch/decode definitions: widths, reset PC, sequencer states, skid payload.
package fetch_sequencer_pkg;

  localparam int unsigned PC_W = 11;
  localparam int unsigned IW   = 32;

  localparam logic [PC_W-1:0] DEFAULT_RESET_PC = PC_W'(0);

  typedef enum logic [1:0] {
    BOOT       = 2'd0,
    RUN        = 2'd1,
    WAIT_REDIR = 2'd2,
    STOPPED    = 2'd3
  } fetch_state_e;

  // One instruction together with the address it was fetched from.
  typedef struct packed {
    logic [IW-1:0]   ir;
    logic [PC_W-1:0] pc;
  } fetch_entry_t;

  // Sequential fetch address; the PC width makes the top address wrap to zero.
  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
    return pc + PC_W'(1);
  endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry {IR, PC} holding register that absorbs the read in flight when the decoder stalls.
module fetch_skid_buffer
  import fetch_sequencer_pkg::*;
(
  input  logic            CLK,
  input  logic            N_RST,
  input  logic            load,
  input  logic [IW-1:0]   load_ir,
  input  logic [PC_W-1:0] load_pc,
  input  logic            unload,
  input  logic            flush,
  output logic            full,
  output logic [IW-1:0]   ir,
  output logic [PC_W-1:0] pc
);

  logic         full_q;
  logic         full_d;
  fetch_entry_t entry_q;
  fetch_entry_t entry_d;

  // Flush beats load beats unload; load and unload never coincide in the sequencer.
  always_comb begin
    full_d  = full_q;
    entry_d = entry_q;
    if (flush) begin
      full_d = 1'b0;
    end else if (load) begin
      full_d     = 1'b1;
      entry_d.ir = load_ir;
      entry_d.pc = load_pc;
    end else if (unload) begin
      full_d = 1'b0;
    end
  end

  // Entry state register.
  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) begin
      full_q  <= 1'b0;
      entry_q <= '0;
    end else begin
      full_q  <= full_d;
      entry_q <= entry_d;
    end
  end

  assign full = full_q;
  assign ir   = entry_q.ir;
  assign pc   = entry_q.pc;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the fetch PC, drives a synchronous-read IMEM and
// presents IR/PC/VALID to the decoder with stall skid, halt squash and redirect handling.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            CLK,
  input  logic            N_RST,
  output logic            IMEM_RE,
  output logic [PC_W-1:0] IMEM_ADDR,
  input  logic [IW-1:0]   IMEM_RDATA,
  output logic [IW-1:0]   IR,
  output logic [PC_W-1:0] PC,
  output logic            VALID,
  input  logic            STALL,
  input  logic            HALT,
  input  logic            REDIR_VALID,
  input  logic [PC_W-1:0] REDIR_PC,
  input  logic            REDIR_STOP,
  output logic            HALTED
);

  fetch_state_e    state_q;
  fetch_state_e    state_d;
  logic [PC_W-1:0] fetch_pc_q;
  logic [PC_W-1:0] fetch_pc_d;
  logic            pend_q;
  logic            pend_d;
  logic [PC_W-1:0] pend_pc_q;
  logic [PC_W-1:0] pend_pc_d;
  logic [IW-1:0]   ir_q;
  logic [IW-1:0]   ir_d;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;
  logic            valid_q;
  logic            valid_d;
  logic            halted_q;
  logic            halted_d;

  logic            imem_re_c;
  logic            adv_c;
  logic            skid_load_c;
  logic            skid_unload_c;
  logic            skid_flush_c;
  logic            skid_full;
  logic [IW-1:0]   skid_ir;
  logic [PC_W-1:0] skid_pc;

  fetch_skid_buffer u_skid (
    .CLK     (CLK),
    .N_RST   (N_RST),
    .load    (skid_load_c),
    .load_ir (IMEM_RDATA),
    .load_pc (pend_pc_q),
    .unload  (skid_unload_c),
    .flush   (skid_flush_c),
    .full    (skid_full),
    .ir      (skid_ir),
    .pc      (skid_pc)
  );

  // Next-state, issue gating and decoder-register update.
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    pend_pc_d     = pend_pc_q;
    ir_d          = ir_q;
    pc_d          = pc_q;
    valid_d       = valid_q;
    halted_d      = halted_q;
    imem_re_c     = 1'b0;
    skid_load_c   = 1'b0;
    skid_unload_c = 1'b0;
    skid_flush_c  = 1'b0;
    adv_c         = ~valid_q | ~STALL;

    unique case (state_q)
      BOOT: begin
        state_d    = RUN;
        fetch_pc_d = RESET_PC;
        valid_d    = 1'b0;
      end

      RUN: begin
        if (REDIR_VALID) begin
          // The redirect is older than anything in IR/skid/flight, so all of it is dropped.
          valid_d      = 1'b0;
          skid_flush_c = 1'b1;
          if (REDIR_STOP) begin
            state_d  = STOPPED;
            halted_d = 1'b1;
          end else begin
            fetch_pc_d = REDIR_PC;
          end
        end else if (HALT) begin
          valid_d      = 1'b0;
          skid_flush_c = 1'b1;
          state_d      = WAIT_REDIR;
        end else begin
          // At most one read may be in flight while the decoder is stalled.
          imem_re_c = ~(valid_q & STALL) & ~skid_full;
          if (imem_re_c) begin
            fetch_pc_d = pc_inc(fetch_pc_q);
            pend_pc_d  = fetch_pc_q;
          end
          if (adv_c) begin
            if (skid_full) begin
              ir_d          = skid_ir;
              pc_d          = skid_pc;
              valid_d       = 1'b1;
              skid_unload_c = 1'b1;
            end else if (pend_q) begin
              ir_d    = IMEM_RDATA;
              pc_d    = pend_pc_q;
              valid_d = 1'b1;
            end else begin
              valid_d = 1'b0;
            end
          end else if (pend_q) begin
            skid_load_c = 1'b1;
          end
        end
      end

      WAIT_REDIR: begin
        valid_d = 1'b0;
        if (REDIR_VALID) begin
          if (REDIR_STOP) begin
            state_d  = STOPPED;
            halted_d = 1'b1;
          end else begin
            fetch_pc_d = REDIR_PC;
            state_d    = RUN;
          end
        end
      end

      STOPPED: begin
        valid_d  = 1'b0;
        halted_d = 1'b1;
      end

      default: begin
        state_d = BOOT;
        valid_d = 1'b0;
      end
    endcase

    pend_d = imem_re_c;
  end

  // Sequencer state, fetch PC, in-flight tracking and decoder-facing registers.
  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) begin
      state_q    <= BOOT;
      fetch_pc_q <= RESET_PC;
      pend_q     <= 1'b0;
      pend_pc_q  <= RESET_PC;
      ir_q       <= '0;
      pc_q       <= '0;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pend_q     <= pend_d;
      pend_pc_q  <= pend_pc_d;
      ir_q       <= ir_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      halted_q   <= halted_d;
    end
  end

  assign IMEM_RE   = imem_re_c;
  assign IMEM_ADDR = fetch_pc_q;
  assign IR        = ir_q;
  assign PC        = pc_q;
  assign VALID     = valid_q;
  assign HALTED    = halted_q;

endmodule
